// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   typedef logic [$clog2(NREGS_DEF)-1:0] reg_id_t;
   typedef logic [XLEN_DEF-1:0]          xword_t;

endpackage

// File: rtl/regfile_if.sv
// Write, read and reserve bundle of the multi-port register file.
interface regfile_if
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = 2,
   parameter int NWR   = 1
);

   localparam int IDW = $clog2(NREGS);

   logic [NWR-1:0]      wr_en;
   logic [NWR*IDW-1:0]  wr_id;
   logic [NWR*XLEN-1:0] wr_data;
   logic [NRD*IDW-1:0]  rd_id;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                rsv_en;
   logic [IDW-1:0]      rsv_id;
   logic                any_busy;

   modport master (
      output wr_en, wr_id, wr_data,
      output rd_id, rsv_en, rsv_id,
      input  rd_data, rd_busy, any_busy
   );

   modport slave (
      input  wr_en, wr_id, wr_data,
      input  rd_id, rsv_en, rsv_id,
      output rd_data, rd_busy, any_busy
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write flags per register, with writeback-cycle busy bypass.
module regfile_scoreboard #(
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter int NWR      = 1,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   localparam int IDW     = $clog2(NREGS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rsv_en,
   input  logic [IDW-1:0]     rsv_id,
   input  logic [NWR-1:0]     wr_en,
   input  logic [NWR*IDW-1:0] wr_id,
   input  logic [NRD*IDW-1:0] rd_id,
   output logic [NREGS-1:0]   busy,
   output logic [NRD-1:0]     rd_busy
);

   logic [NREGS-1:0] clr;
   logic [NREGS-1:0] set;
   logic             rsv_ok;

   assign rsv_ok = rsv_en &&
      !(ZERO_REG != 0 && rsv_id == '0);

   always_comb begin
      clr = '0;
      set = '0;
      for (int k = 0; k < NWR; k++) begin
         if (wr_en[k]) clr[wr_id[k*IDW +: IDW]] = 1'b1;
      end
      if (rsv_ok) set[rsv_id] = 1'b1;
   end

   // set after clear: a new reservation outlives a completing write
   always_ff @(posedge clk) begin
      if (rst) busy <= '0;
      else     busy <= (busy & ~clr) | set;
   end

   always_comb begin
      logic [IDW-1:0] id;
      id      = '0;
      rd_busy = '0;
      for (int j = 0; j < NRD; j++) begin
         id         = rd_id[j*IDW +: IDW];
         rd_busy[j] = busy[id] &
            ~((BYPASS != 0) && clr[id]);
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int NRD      = 2,
   parameter int NWR      = 1,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input logic      clk,
   input logic      rst,
   regfile_if.slave bus
);

   localparam int IDW = $clog2(NREGS);

   logic [XLEN-1:0]  regs   [NREGS];
   logic [XLEN-1:0]  wr_val [NREGS];
   logic [NREGS-1:0] wr_hit;
   logic [NREGS-1:0] busy;

   // ascending scan so the highest-index port wins a conflict
   always_comb begin
      logic [IDW-1:0] id;
      id     = '0;
      wr_hit = '0;
      for (int i = 0; i < NREGS; i++) wr_val[i] = '0;
      for (int k = 0; k < NWR; k++) begin
         id = bus.wr_id[k*IDW +: IDW];
         if (bus.wr_en[k] &&
             !(ZERO_REG != 0 && id == '0)) begin
            wr_hit[id] = 1'b1;
            wr_val[id] = bus.wr_data[k*XLEN +: XLEN];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++)
            if (wr_hit[i]) regs[i] <= wr_val[i];
      end
   end

   always_comb begin
      logic [IDW-1:0] id;
      id          = '0;
      bus.rd_data = '0;
      for (int j = 0; j < NRD; j++) begin
         id = bus.rd_id[j*IDW +: IDW];
         bus.rd_data[j*XLEN +: XLEN] = regs[id];
         if (BYPASS != 0 && wr_hit[id])
            bus.rd_data[j*XLEN +: XLEN] = wr_val[id];
         if (ZERO_REG != 0 && id == '0)
            bus.rd_data[j*XLEN +: XLEN] = '0;
      end
   end

   regfile_scoreboard #(
      .NREGS    (NREGS),
      .NRD      (NRD),
      .NWR      (NWR),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk     (clk),
      .rst     (rst),
      .rsv_en  (bus.rsv_en),
      .rsv_id  (bus.rsv_id),
      .wr_en   (bus.wr_en),
      .wr_id   (bus.wr_id),
      .rd_id   (bus.rd_id),
      .busy    (busy),
      .rd_busy (bus.rd_busy)
   );

   assign bus.any_busy = |busy;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file with an integrated busy scoreboard. Successor to the single-write, dual-read core register file.
- Sits in the decode/writeback stages of the pipelined core.
- Provides NRD combinational read ports and NWR synchronous write ports.
- Optional same-cycle write-to-read bypass; optional hard-wired zero register.
- Per-register pending bits let decode stall on RAW hazards.

Parameters:
- XLEN, 32: data width in bits.
- NREGS, 32: number of architectural registers, power of two, at least 2. IDW = $clog2(NREGS).
- NRD, 2: number of read ports, 1..4.
- NWR, 1: number of write ports, 1..2.
- BYPASS, 1: 1 = read returns same-cycle write data; 0 = read returns stored value.
- ZERO_REG, 1: 1 = register 0 reads 0, ignores writes, never becomes busy.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  NWR  per-port write enable.
- wr_id  in  NWR*IDW  per-port write address; port k at bits [k*IDW +: IDW].
- wr_data  in  NWR*XLEN  per-port write data.
- rd_id  in  NRD*IDW  per-port read address.
- rd_data  out  NRD*XLEN  per-port read data, combinational.
- rd_busy  out  NRD  per-port busy flag of the addressed register, combinational.
- rsv_en  in  1  reserve (mark pending) register rsv_id this cycle.
- rsv_id  in  IDW  register to reserve.
- any_busy  out  1  OR of all busy bits.

Behaviour:
- Reset:
  - On a posedge with rst=1, all registers and all busy bits clear to 0. Writes and reserves in that cycle are ignored.
  - After the reset edge: rd_data=0, rd_busy=0, any_busy=0.
  - Reset mid-operation discards pending reservations.
- Write (latency 1): on posedge with wr_en[k]=1, reg[wr_id[k]] <= wr_data[k].
- Write conflict: if multiple ports target the same id in one cycle, the highest-index port wins.
- Zero register: with ZERO_REG=1, writes to id 0 are dropped, and rd_data and rd_busy for id 0 are always 0.
- Read (latency 0): rd_data[j] = reg[rd_id[j]].
- Bypass: with BYPASS=1, if any wr_en[k] targets rd_id[j] this cycle, rd_data[j] returns the winning wr_data instead. The zero-register rule overrides bypass.
- Scoreboard:
  - busy[i] is set on posedge when rsv_en=1 and rsv_id=i.
  - busy[i] is cleared on posedge when any enabled write targets i.
  - Reserve and write to the same id in the same cycle: busy stays 1, because the new reservation supersedes the completing one.
  - Reserving an already-busy id leaves it busy. The bit is a flag, not a counter; a single writeback clears it.
  - rsv_id=0 with ZERO_REG=1 is ignored.
- Busy bypass:
  - rd_busy[j] reflects the busy bit masked by a same-cycle clearing write when BYPASS=1, so a waiting consumer sees busy=0 in the writeback cycle.
  - A same-cycle reserve is not visible until the next cycle.
- Out-of-range ids cannot occur (NREGS is a power of two).
- No X propagation: all storage is cleared by reset.

Decomposition:
- Shared package regfile_pkg:
  - XLEN_DEF=32, NREGS_DEF=32.
  - typedef logic [$clog2(NREGS_DEF)-1:0] reg_id_t.
  - typedef logic [XLEN_DEF-1:0] xword_t.
- Sub-module regfile_scoreboard: NREGS busy bits.
  - Inputs: reserve inputs and the per-port write-enable/id vectors.
  - Outputs: the busy vector and the bypass-masked per-read-port busy flags.
- The regfile_mp top holds the data array, write-priority mux and read/bypass mux.

Test Plan:
- Reset clears state: write 0xDEADBEEF to x5, assert rst one cycle, read x5 -> rd_data=0, rd_busy=0, any_busy=0.
- Zero register: write 0x12345678 to x0, rsv_en on x0 -> rd_data(x0)=0, rd_busy=0 next cycle, any_busy stays 0.
- Bypass: BYPASS=1, write 0xA5A5A5A5 to x7 while rd_id[0]=7 -> rd_data[0]=0xA5A5A5A5 in the same cycle. BYPASS=0 -> old value that cycle, new value next cycle.
- Write conflict: NWR=2, both ports write x3 with 0x1 and 0x2 in one cycle -> x3=0x2 next cycle, bypass read also 0x2.
- Scoreboard:
  - Reserve x9 at cycle 0 -> rd_busy=1 from cycle 1.
  - Write x9 at cycle 4 -> rd_busy=0 at cycle 4 (bypassed), busy bit clear at cycle 5.
  - Reserve and write x9 together -> busy=1 the next cycle.
- Multi-port sweep: NRD=4, write i*0x11 to x1..x31, read four distinct ids per cycle -> every port returns the matching value.
